// File: rtl/key_expansion.sv
// key_expansion: AES-128 key schedule producing round keys 0..NR on the fly.
// The cipher key is loaded once; each accepted advance derives the next round
// key from the current one, so no key store is kept.
// Build option: define KEY_EXPANSION_SYNC_SBOX_EN for a registered S-box
// (block-RAM style), which inserts a CALC cycle and gives a 2-cycle step.
// Without it the S-box is combinational and each step takes 1 cycle.
module key_expansion #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic         advance,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         valid,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        CALC = 2'd2
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bits [8*(255-x)+7 -: 8]; 8*(255-x)+7 is just {~x, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One schedule step: sub is SubWord(RotWord(w3)) of the current key.
    function automatic logic [127:0] next_key(input logic [127:0] k,
                                              input logic [31:0]  sub,
                                              input logic [7:0]   rcon);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = sub ^ {rcon, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_e       state_q, state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;
    logic [31:0]  sub_w;
    logic         step;

`ifdef KEY_EXPANSION_SYNC_SBOX_EN
    logic [31:0] sub_q;

    // Registered S-box read of RotWord(w3); consumed in the following CALC cycle.
    // NOTE: no reset on this lookup register so it maps onto a synchronous
    // RAM read port; it is only used in CALC, which always follows a HOLD
    // cycle that has already written it.
    always_ff @(posedge clk) begin
        sub_q <= sub_word(rot_word(round_key_q[31:0]));
    end

    assign sub_w = sub_q;
`else
    assign sub_w = sub_word(rot_word(round_key_q[31:0]));
`endif

    // Next-state logic: load wins, otherwise HOLD/CALC decide whether to step.
    always_comb begin
        // NOTE: every target gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        round_key_d = round_key_q;
        round_d     = round_q;
        rcon_d      = rcon_q;
        step        = 1'b0;

        if (load) begin
            round_key_d = key;
            round_d     = 4'd0;
            rcon_d      = 8'h01;
            state_d     = HOLD;
        end else begin
            case (state_q)
                HOLD: begin
                    if (advance && (round_q < LAST_ROUND)) begin
`ifdef KEY_EXPANSION_SYNC_SBOX_EN
                        state_d = CALC;
`else
                        step = 1'b1;
`endif
                    end
                end
                CALC: begin
                    step    = 1'b1;
                    state_d = HOLD;
                end
                default: begin
                    state_d = state_q;
                end
            endcase

            if (step) begin
                round_key_d = next_key(round_key_q, sub_w, rcon_q);
                round_d     = round_q + 4'd1;
                rcon_d      = xtime(rcon_q);
            end
        end

        valid_d = (state_d == HOLD);
        done_d  = valid_d && (round_d == LAST_ROUND);
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            round_q     <= 4'd0;
            rcon_q      <= 8'h01;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // values from before this edge, independent of statement order.
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_q     <= round_d;
            rcon_q      <= rcon_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign round_key = round_key_q;
    assign round     = round_q;
    assign valid     = valid_q;
    assign done      = done_q;

endmodule
